uart_matmul_sequencer: RTL and testbench

//  Host-link controller between the byte-level UART (RX/TX) and the matrix-multiply core.

---
 rtl/uart_matmul_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_uart_matmul_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matmul_sequencer.sv
// Host-link sequencer between a byte UART and a matrix-multiply core.
// A session is a sync byte, then E bytes of A and E bytes of B, written
// straight into the core's operand buffers. The core is then started, and
// once it completes, the E results are streamed back MSB byte first.
// Inter-byte silence while loading, or a framing error, aborts to IDLE.
module uart_matmul_sequencer #(
  parameter int         N         = 4,
  parameter int         RES_W     = 24,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_error,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [RES_W-1:0]  res_rdata,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              busy,
  output logic              err
);

  localparam int E         = N * N;
  localparam int RES_BYTES = RES_W / 8;
  localparam int BCNT_W    = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(E - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(RES_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  // RD_LAT is the cycle in which the buffer's registered read data arrives;
  // it is captured at the end of that cycle.
  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_MM,
    RD_RES,
    RD_LAT,
    TX_REQ,
    TX_WAIT
  } state_t;

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_nxt;
  logic [TMO_W-1:0]    tmo_q, tmo_nxt;
  logic [RES_W-1:0]    shift_q;
  logic                shift_ld;
  logic                shift_sh;

  // idx is both the operand write address and the result read address.
  assign mem_addr = idx_q;
  assign busy     = (state_q != IDLE);

  // Control registers: state, element index, byte counter, inter-byte timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      bcnt_q  <= bcnt_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  // Result shift register: loaded from the core, shifted one byte per sent byte.
  always_ff @(posedge clk) begin
    if (shift_ld) begin
      shift_q <= res_rdata;
    end else if (shift_sh) begin
      shift_q <= shift_q << 8;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    bcnt_nxt  = bcnt_q;
    tmo_nxt   = '0;
    shift_ld  = 1'b0;
    shift_sh  = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    mem_wdata = 8'h00;
    mm_start  = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_done && (rx_data == SYNC_BYTE)) begin
          state_nxt = LOAD_A;
          idx_nxt   = '0;
        end
      end

      LOAD_A, LOAD_B: begin
        mem_sel = (state_q == LOAD_B);
        // A framing error outranks a byte; a byte outranks the timeout.
        if (rx_error) begin
          err       = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (rx_done) begin
          mem_we    = 1'b1;
          mem_wdata = rx_data;
          if (idx_q == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = (state_q == LOAD_A) ? LOAD_B : START;
          end else begin
            idx_nxt = idx_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err       = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          tmo_nxt = tmo_q + 1'b1;
        end
      end

      START: begin
        mm_start  = 1'b1;
        state_nxt = WAIT_MM;
      end

      WAIT_MM: begin
        if (mm_done) begin
          state_nxt = RD_RES;
          idx_nxt   = '0;
        end
      end

      RD_RES: begin
        state_nxt = RD_LAT;
      end

      RD_LAT: begin
        shift_ld  = 1'b1;
        bcnt_nxt  = '0;
        state_nxt = TX_REQ;
      end

      TX_REQ: begin
        tx_data = shift_q[RES_W-1 -: 8];
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = TX_WAIT;
        end
      end

      TX_WAIT: begin
        tx_data = shift_q[RES_W-1 -: 8];
        if (tx_done) begin
          if (bcnt_q != BCNT_LAST) begin
            shift_sh  = 1'b1;
            bcnt_nxt  = bcnt_q + 1'b1;
            state_nxt = TX_REQ;
          end else if (idx_q != IDX_LAST) begin
            idx_nxt   = idx_q + 1'b1;
            state_nxt = RD_RES;
          end else begin
            idx_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_matmul_sequencer.sv
module tb_uart_matmul_sequencer;

  localparam int N       = 4;
  localparam int E       = N * N;
  localparam int RES_W   = 24;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              rx_error;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [RES_W-1:0]  res_rdata;
  logic              mm_start;
  logic              mm_done;
  logic              busy;
  logic              err;

  logic              mdl_busy;
  logic              hold_busy;
  logic [RES_W-1:0]  res_mem [E];

  int vecs = 0;
  int fails = 0;
  int cyc = 0;
  int mm_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int we_cnt = 0;
  int tx_cnt = 0;
  int last_rx_cyc = 0;
  bit rst_evt = 1'b0;

  logic [12:0] wq [$];
  logic [7:0]  tq [$];

  always #5 clk = ~clk;

  assign tx_busy = mdl_busy | hold_busy;

  uart_matmul_sequencer #(
    .N(N), .RES_W(RES_W), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .res_rdata(res_rdata), .mm_start(mm_start), .mm_done(mm_done),
    .busy(busy), .err(err)
  );

  // Result buffer with one cycle of read latency.
  always @(posedge clk) res_rdata <= res_mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Write scoreboard and event counters, sampled mid-cycle.
  initial begin
    logic [12:0] exp_w;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        vecs++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL mem_write_unexpected: got sel/addr/data=%h, none required", {mem_sel, mem_addr, mem_wdata});
        end else begin
          exp_w = wq.pop_front();
          if ({mem_sel, mem_addr, mem_wdata} !== exp_w) begin
            fails++;
            $display("FAIL mem_write: got sel/addr/data=%h required %h", {mem_sel, mem_addr, mem_wdata}, exp_w);
          end
        end
      end
      if (mm_start) mm_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Transmitter model plus byte scoreboard.
  initial begin
    logic [7:0] cap;
    logic [7:0] exp_b;
    mdl_busy = 1'b0;
    tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_cnt++;
        vecs++;
        cap = tx_data;
        if (tq.size() == 0) begin
          fails++;
          $display("FAIL tx_byte_unexpected: got %h, none required", tx_data);
        end else begin
          exp_b = tq.pop_front();
          if (tx_data !== exp_b) begin
            fails++;
            $display("FAIL tx_byte: got %h required %h", tx_data, exp_b);
          end
        end
        @(posedge clk); #1 mdl_busy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        mdl_busy = 1'b0;
        tx_done  = 1'b1;
        @(negedge clk);
        if (!rst_evt) begin
          vecs++;
          if (tx_data !== cap) begin
            fails++;
            $display("FAIL tx_data_stable: got %h required %h", tx_data, cap);
          end
        end
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_rx_error();
    @(posedge clk); #1 rx_error = 1'b1;
    @(posedge clk); #1 rx_error = 1'b0;
  endtask

  task automatic pulse_mm_done();
    @(posedge clk); #1 mm_done = 1'b1;
    @(posedge clk); #1 mm_done = 1'b0;
  endtask

  task automatic load_matrix(input logic sel, input logic [7:0] seed, input int count);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = seed + 8'(i * 7);
      wq.push_back({sel, 4'(i), b});
      rx_byte(b);
    end
  endtask

  task automatic push_results();
    for (int i = 0; i < E; i++) begin
      tq.push_back(res_mem[i][23:16]);
      tq.push_back(res_mem[i][15:8]);
      tq.push_back(res_mem[i][7:0]);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({tx_start, tx_data, mem_we, mem_sel, mem_addr, mem_wdata, mm_start, busy, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {tx_start, tx_data, mem_we, mem_sel, mem_addr, mem_wdata, mm_start, busy, err});
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_sync_load();
    int w0;
    rx_byte(8'h3C);
    vecs++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL non_sync_dropped: busy got %b required 0", busy);
    end
    rx_byte(8'hA5);
    vecs++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL sync_enters_load: busy got %b required 1", busy);
    end
    w0 = we_cnt;
    load_matrix(1'b0, 8'h10, E);
    load_matrix(1'b1, 8'h80, E);
    vecs++;
    if ((we_cnt - w0) != 2 * E || wq.size() != 0) begin
      fails++;
      $display("FAIL load_write_count: got %0d pending %0d required %0d pending 0", we_cnt - w0, wq.size(), 2 * E);
    end
  endtask

  // Entered in the START cycle, straight after the last B byte.
  task automatic test_compute_tx();
    int m0, t0;
    bit ok;
    m0 = mm_cnt;
    t0 = tx_cnt;
    vecs++;
    if (mm_start !== 1'b1) begin
      fails++;
      $display("FAIL mm_start_after_load: got %b required 1", mm_start);
    end
    mm_done = 1'b1;
    @(posedge clk); #1 mm_done = 1'b0;
    for (int i = 0; i < E; i++) res_mem[i] = 24'h123456;
    push_results();
    repeat (8) begin @(posedge clk); #1; end
    vecs++;
    if (tx_cnt != t0 || busy !== 1'b1 || (mm_cnt - m0) != 1) begin
      fails++;
      $display("FAIL start_cycle_done_ignored: tx %0d busy %b mm_start cycles %0d required tx 0 busy 1 cycles 1",
               tx_cnt - t0, busy, mm_cnt - m0);
    end
    pulse_mm_done();
    wait_idle(2000, ok);
    vecs++;
    if (!ok) begin
      fails++;
      $display("FAIL result_stream_timeout: busy got %b required 0", busy);
    end
    vecs++;
    if ((tx_cnt - t0) != 3 * E || tq.size() != 0 || (mm_cnt - m0) != 1) begin
      fails++;
      $display("FAIL result_stream_count: tx %0d pending %0d mm cycles %0d required tx %0d pending 0 cycles 1",
               tx_cnt - t0, tq.size(), mm_cnt - m0, 3 * E);
    end
  endtask

  task automatic test_timeout();
    int j, e0, e1;
    bit ok;
    e0 = err_cnt;
    rx_byte(8'hA5);
    load_matrix(1'b0, 8'h21, 5);
    j = last_rx_cyc;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      @(negedge clk);
      if (err_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
    vecs++;
    if (!ok || (err_cyc - j) != TIMEOUT) begin
      fails++;
      $display("FAIL timeout_err_cycle: seen %b after %0d cycles required 1 after %0d", ok, err_cyc - j, TIMEOUT);
    end
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || (err_cnt - e0) != 1) begin
      fails++;
      $display("FAIL timeout_idle: busy %b err cycles %0d required busy 0 cycles 1", busy, err_cnt - e0);
    end
    rx_byte(8'hA5);
    wq.push_back({1'b0, 4'd0, 8'h5A});
    rx_byte(8'h5A);
    j  = last_rx_cyc;
    e1 = err_cnt;
    while (cyc < j + TIMEOUT - 1) begin @(posedge clk); #1; end
    wq.push_back({1'b0, 4'd1, 8'hC3});
    rx_byte(8'hC3);
    vecs++;
    if (err_cnt != e1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL byte_beats_timeout: err cycles %0d busy %b required 0 and 1", err_cnt - e1, busy);
    end
    pulse_rx_error();
    vecs++;
    if ((err_cnt - e1) != 1 || busy !== 1'b0 || wq.size() != 0) begin
      fails++;
      $display("FAIL restart_abort: err cycles %0d busy %b pending %0d required 1 0 0", err_cnt - e1, busy, wq.size());
    end
  endtask

  task automatic test_rx_error_load_b();
    int e0;
    e0 = err_cnt;
    rx_byte(8'hA5);
    load_matrix(1'b0, 8'h33, E);
    load_matrix(1'b1, 8'h44, 3);
    pulse_rx_error();
    vecs++;
    if ((err_cnt - e0) != 1 || busy !== 1'b0 || wq.size() != 0) begin
      fails++;
      $display("FAIL rx_error_load_b: err cycles %0d busy %b pending %0d required 1 0 0", err_cnt - e0, busy, wq.size());
    end
    pulse_rx_error();
    vecs++;
    if ((err_cnt - e0) != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rx_error_idle_ignored: err cycles %0d busy %b required 1 0", err_cnt - e0, busy);
    end
  endtask

  task automatic test_tx_busy();
    int e0, t0, held;
    bit ok;
    e0 = err_cnt;
    t0 = tx_cnt;
    hold_busy = 1'b1;
    for (int i = 0; i < E; i++) res_mem[i] = {8'(i + 1), 8'(8'hF0 - i), 8'(8'h3C + i * 5)};
    push_results();
    rx_byte(8'hA5);
    load_matrix(1'b0, 8'h05, E);
    load_matrix(1'b1, 8'h90, E);
    repeat (9) begin @(posedge clk); #1; end
    pulse_mm_done();
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) held++;
    end
    vecs++;
    if (held != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL tx_busy_hold: tx_start cycles %0d busy %b required 0 and 1", held, busy);
    end
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_tx_start(20, ok);
    vecs++;
    if (!ok) begin
      fails++;
      $display("FAIL tx_after_busy_drop: tx_start seen %b required 1", ok);
    end
    rx_byte(8'hA5);
    pulse_rx_error();
    pulse_mm_done();
    wait_idle(2000, ok);
    vecs++;
    if (!ok || (tx_cnt - t0) != 3 * E || tq.size() != 0 || err_cnt != e0) begin
      fails++;
      $display("FAIL tx_wait_ignores: idle %b tx %0d pending %0d err %0d required 1 %0d 0 0",
               ok, tx_cnt - t0, tq.size(), err_cnt - e0, 3 * E);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int i = 0; i < E; i++) res_mem[i] = 24'hABCDEF;
    push_results();
    rx_byte(8'hA5);
    load_matrix(1'b0, 8'h61, E);
    load_matrix(1'b1, 8'h72, E);
    repeat (9) begin @(posedge clk); #1; end
    pulse_mm_done();
    wait_tx_start(30, ok);
    if (ok) wait_tx_start(30, ok);
    vecs++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_setup_tx: tx_start seen %b required 1", ok);
    end
    @(posedge clk); #3;
    rst_evt = 1'b1;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({tx_start, mm_start, busy, err, mem_we, tx_data} !== '0) begin
      fails++;
      $display("FAIL async_reset_outputs: got %h required 0", {tx_start, mm_start, busy, err, mem_we, tx_data});
    end
    tq.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    rst_evt = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy got %b required 0", busy);
    end
    rx_byte(8'hA5);
    wq.push_back({1'b0, 4'd0, 8'h77});
    rx_byte(8'h77);
    pulse_rx_error();
    vecs++;
    if (busy !== 1'b0 || wq.size() != 0) begin
      fails++;
      $display("FAIL post_reset_session: busy %b pending %0d required 0 0", busy, wq.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    rx_error  = 1'b0;
    mm_done   = 1'b0;
    hold_busy = 1'b0;
    for (int i = 0; i < E; i++) res_mem[i] = '0;
    test_reset();
    test_sync_load();
    test_compute_tx();
    test_timeout();
    test_rx_error_load_b();
    test_tx_busy();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
